// File: rtl/data_mem_responder.sv
// data_mem_responder
//   Multi-cycle responder for a stalling CPU data-memory port. It serves
//   load and store requests from a single-port, word-wide synchronous SRAM
//   whose read data is registered. Sub-word stores are done as a
//   read-modify-write. Every request finishes with a one-cycle ack pulse.
//
// Ports
//   clk, rstN            clock (rising edge); synchronous active-low reset
//   address, writeData   CPU byte address and store data
//   mode                 access size: 00 word, 01 half, 10 byte, 11 reserved
//   memRead, memWrite    request strobes, held by the CPU until ack
//   readData             load result, zero-extended; held until the next load
//   ack, fault           completion pulse; fault=1 marks a rejected request
//   sramAddr/WData/We/Re SRAM command outputs (all registered)
//   sramRData            SRAM read data, valid the cycle after sramRe
module data_mem_responder #(
  parameter int ADDR_WIDTH = 10
) (
  input  logic                  clk,
  input  logic                  rstN,
  input  logic [31:0]           address,
  input  logic [31:0]           writeData,
  input  logic [1:0]            mode,
  input  logic                  memRead,
  input  logic                  memWrite,
  output logic [31:0]           readData,
  output logic                  ack,
  output logic                  fault,
  output logic [ADDR_WIDTH-1:0] sramAddr,
  output logic [31:0]           sramWData,
  output logic                  sramWe,
  output logic                  sramRe,
  input  logic [31:0]           sramRData
);

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] READ  = 3'd1;
  localparam logic [2:0] WAIT  = 3'd2;
  localparam logic [2:0] WRITE = 3'd3;
  localparam logic [2:0] ACK   = 3'd4;

  localparam logic [1:0] M_WORD = 2'b00;
  localparam logic [1:0] M_HALF = 2'b01;
  localparam logic [1:0] M_BYTE = 2'b10;

  logic [2:0]  state;
  logic [1:0]  lane;     // latched address[1:0]
  logic [1:0]  lmode;    // latched mode
  logic        lload;    // latched request is a load
  logic [31:0] lwdata;   // latched store data

  // Acceptance-time checks, evaluated on the live inputs in IDLE.
  logic req, req_fault;
  assign req = memRead | memWrite;

  always_comb begin
    req_fault = 1'b0;
    if (memRead && memWrite)                              req_fault = 1'b1;
    if (mode == 2'b11)                                    req_fault = 1'b1;
    if (mode == M_HALF && address[0])                     req_fault = 1'b1;
    if (mode == M_WORD && address[1:0] != 2'b00)          req_fault = 1'b1;
    // Any address bit above the SRAM's word range makes the access invalid.
    if ((address >> (ADDR_WIDTH + 2)) != 32'd0)           req_fault = 1'b1;
  end

  // Load result: selected lane of the returned word, zero-extended.
  logic [31:0] load_val;
  always_comb begin
    load_val = sramRData;
    case (lmode)
      M_HALF:  load_val = {16'd0, sramRData[{lane[1], 4'b0000} +: 16]};
      M_BYTE:  load_val = {24'd0, sramRData[{lane, 3'b000} +: 8]};
      default: load_val = sramRData;
    endcase
  end

  // Merge for sub-word stores: only the addressed lane takes new data.
  logic [31:0] merged;
  always_comb begin
    merged = sramRData;
    if (lmode == M_HALF) merged[{lane[1], 4'b0000} +: 16] = lwdata[15:0];
    else                 merged[{lane, 3'b000} +: 8]      = lwdata[7:0];
  end

  // Outputs are registered by computing them alongside the next state, so
  // sramRe/sramWe/ack are high exactly while in READ/WRITE/ACK.
  always_ff @(posedge clk) begin
    if (!rstN) begin
      state     <= IDLE;
      lane      <= 2'b00;
      lmode     <= M_WORD;
      lload     <= 1'b0;
      lwdata    <= 32'd0;
      readData  <= 32'd0;
      ack       <= 1'b0;
      fault     <= 1'b0;
      sramAddr  <= '0;
      sramWData <= 32'd0;
      sramWe    <= 1'b0;
      sramRe    <= 1'b0;
    end else begin
      ack    <= 1'b0;
      sramWe <= 1'b0;
      sramRe <= 1'b0;
      case (state)
        IDLE: begin
          if (req) begin
            lane   <= address[1:0];
            lmode  <= mode;
            lload  <= memRead;
            lwdata <= writeData;
            fault  <= req_fault;
            if (req_fault) begin
              state <= ACK;
              ack   <= 1'b1;
            end else begin
              sramAddr <= address[ADDR_WIDTH+1:2];
              if (memWrite && mode == M_WORD) begin
                state     <= WRITE;
                sramWe    <= 1'b1;
                sramWData <= writeData;
              end else begin
                state  <= READ;
                sramRe <= 1'b1;
              end
            end
          end
        end
        READ: state <= WAIT;
        WAIT: begin
          // sramRData holds the word read during READ.
          if (lload) begin
            readData <= load_val;
            state    <= ACK;
            ack      <= 1'b1;
          end else begin
            sramWData <= merged;
            sramWe    <= 1'b1;
            state     <= WRITE;
          end
        end
        WRITE: begin
          state <= ACK;
          ack   <= 1'b1;
        end
        ACK:     state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_data_mem_responder.sv
module tb_data_mem_responder;
  localparam int AW = 10;

  logic          clk = 1'b0;
  logic          rstN;
  logic [31:0]   address, writeData;
  logic [1:0]    mode;
  logic          memRead, memWrite;
  logic [31:0]   readData;
  logic          ack, fault;
  logic [AW-1:0] sramAddr;
  logic [31:0]   sramWData;
  logic          sramWe, sramRe;
  logic [31:0]   sramRData;

  always #5 clk = ~clk;

  data_mem_responder #(.ADDR_WIDTH(AW)) dut (
    .clk(clk), .rstN(rstN), .address(address), .writeData(writeData),
    .mode(mode), .memRead(memRead), .memWrite(memWrite),
    .readData(readData), .ack(ack), .fault(fault),
    .sramAddr(sramAddr), .sramWData(sramWData), .sramWe(sramWe),
    .sramRe(sramRe), .sramRData(sramRData)
  );

  function automatic logic [31:0] init_word(input int i);
    return (i * 32'h01010101) ^ 32'h5A5A_0000;
  endfunction

  // Behavioural SRAM: registered read, write on the enable edge.
  logic [31:0] sram [0:(1<<AW)-1];
  bit          sram_init = 1'b0;
  always @(posedge clk) begin
    if (!sram_init) begin
      for (int i = 0; i < (1 << AW); i++) sram[i] <= init_word(i);
      sram_init <= 1'b1;
    end else begin
      if (sramWe) sram[sramAddr] <= sramWData;
      if (sramRe) sramRData <= sram[sramAddr];
    end
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic        flt;
    logic [31:0] rd;
    int          ack_cyc;
    logic        wr;
    logic [9:0]  wa;
    logic [31:0] ww;
  } exp_t;

  exp_t        q[$];
  logic [31:0] ref_mem [0:(1<<AW)-1];
  logic [31:0] last_rd;
  int          checks = 0, failures = 0;
  bit          started = 1'b0;
  bit          acc = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  // Monitor: pops the scoreboard on every ack and checks SRAM writes.
  always @(negedge clk) begin
    if (started) begin
      if (!rstN) acc = 1'b0;
      else begin
        chk("we_re_exclusive", {31'd0, sramWe & sramRe}, 32'd0);
        if (sramWe || sramRe) acc = 1'b1;
        if (sramWe) begin
          if (q.size() == 0) chk("unexpected_we", 32'd1, 32'd0);
          else begin
            chk("we_for_store", {31'd0, q[0].wr}, 32'd1);
            chk("we_addr", {22'd0, sramAddr}, {22'd0, q[0].wa});
            chk("we_data", sramWData, q[0].ww);
          end
        end
        if (ack) begin
          if (q.size() == 0) chk("unexpected_ack", 32'd1, 32'd0);
          else begin
            exp_t e;
            e = q.pop_front();
            chk("ack_cycle", cyc, e.ack_cyc);
            chk("fault", {31'd0, fault}, {31'd0, e.flt});
            chk("readData", readData, e.rd);
            if (e.flt) chk("fault_no_sram_access", {31'd0, acc}, 32'd0);
          end
          acc = 1'b0;
        end
      end
    end
  end

  // Reference model: byte-mask arithmetic over a word array.
  task automatic issue(input logic rd, input logic wr, input logic [31:0] a,
                       input logic [31:0] wd, input logic [1:0] md, input bit scr);
    exp_t e;
    logic [31:0] old, mask;
    int sh, lat;
    sh   = int'(a[1:0]) * 8;
    old  = ref_mem[a[11:2]];
    mask = (md == 2'd0) ? 32'hFFFF_FFFF : (md == 2'd1) ? (32'hFFFF << sh) : (32'hFF << sh);
    e.flt = (rd && wr) || md == 2'd3 || (md == 2'd1 && a[0]) ||
            (md == 2'd0 && a[1:0] != 2'd0) || (a[31:AW+2] != '0);
    e.wr = 1'b0; e.wa = a[11:2]; e.ww = 32'd0;
    if (e.flt) lat = 1;
    else if (rd) begin
      last_rd = (old & mask) >> sh;
      lat = 3;
    end else begin
      e.wr = 1'b1;
      e.ww = (old & ~mask) | ((wd << sh) & mask);
      ref_mem[a[11:2]] = e.ww;
      lat = (md == 2'd0) ? 2 : 4;
    end
    e.rd = last_rd;
    e.ack_cyc = cyc + lat;
    q.push_back(e);
    memRead = rd; memWrite = wr; address = a; writeData = wd; mode = md;
    if (scr) begin
      @(posedge clk); #1;
      address = $urandom; writeData = $urandom; mode = 2'($urandom);
      memRead = 1'($urandom); memWrite = 1'($urandom);
    end
    for (int n = 0; n < 20 && q.size() > 0; n++) begin
      @(posedge clk); #1;
    end
    if (q.size() > 0) begin
      chk("ack_timeout", 32'd1, 32'd0);
      q.delete();
    end
    memRead = 1'b0; memWrite = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < (1 << AW); i++) ref_mem[i] = init_word(i);
    last_rd = 32'd0;
    rstN = 1'b0; memRead = 1'b0; memWrite = 1'b0;
    address = 32'd0; writeData = 32'd0; mode = 2'd0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_readData", readData, 32'd0);
    chk("rst_ack", {31'd0, ack}, 32'd0);
    chk("rst_fault", {31'd0, fault}, 32'd0);
    chk("rst_sramAddr", {22'd0, sramAddr}, 32'd0);
    chk("rst_sramWData", sramWData, 32'd0);
    chk("rst_sramWe", {31'd0, sramWe}, 32'd0);
    chk("rst_sramRe", {31'd0, sramRe}, 32'd0);
    rstN = 1'b1; started = 1'b1;
    @(posedge clk); #1;

    // Directed: word, byte RMW, halfword.
    issue(0, 1, 32'h10, 32'hDEADBEEF, 2'd0, 0);
    issue(1, 0, 32'h10, 32'h0, 2'd0, 0);
    issue(0, 1, 32'h12, 32'h55, 2'd2, 0);
    issue(1, 0, 32'h12, 32'h0, 2'd2, 0);
    issue(1, 0, 32'h10, 32'h0, 2'd0, 0);
    issue(0, 1, 32'h16, 32'hA5A5_1234, 2'd1, 0);
    issue(1, 0, 32'h16, 32'h0, 2'd1, 0);
    issue(1, 0, 32'h14, 32'h0, 2'd0, 0);
    // Faults.
    issue(1, 0, 32'h11, 32'h0, 2'd1, 0);
    issue(0, 1, 32'h12, 32'h0, 2'd0, 0);
    issue(1, 0, 32'h10, 32'h0, 2'd3, 0);
    issue(1, 0, 32'h0000_1000, 32'h0, 2'd0, 0);
    issue(1, 1, 32'h10, 32'h0, 2'd0, 0);

    // Reset during WAIT of a byte store: nothing written, no ack.
    memWrite = 1'b1; address = 32'h12; writeData = 32'hAA; mode = 2'd2;
    @(posedge clk); #1;       // READ
    @(posedge clk); #1;       // WAIT
    rstN = 1'b0;
    @(posedge clk); #1;
    chk("mid_rst_readData", readData, 32'd0);
    chk("mid_rst_ack", {31'd0, ack}, 32'd0);
    chk("mid_rst_sramWe", {31'd0, sramWe}, 32'd0);
    chk("mid_rst_sramRe", {31'd0, sramRe}, 32'd0);
    chk("mid_rst_sramWData", sramWData, 32'd0);
    chk("mid_rst_sramAddr", {22'd0, sramAddr}, 32'd0);
    memWrite = 1'b0; rstN = 1'b1; last_rd = 32'd0;
    @(posedge clk); #1;
    issue(1, 0, 32'h10, 32'h0, 2'd0, 0);
    chk("rmw_abort_word4", sram[4], ref_mem[4]);

    // Randomized back-to-back traffic with operand scrambling while busy.
    for (int i = 0; i < 300; i++) begin
      logic [31:0] a;
      int k;
      a = ($urandom_range(0, 9) == 0) ? $urandom : 32'($urandom_range(0, 63));
      k = $urandom_range(0, 19);
      issue(k < 9 || k == 19, k >= 9, a, $urandom, 2'($urandom), bit'($urandom));
    end

    for (int i = 0; i < 16; i++) chk("final_sram", sram[i], ref_mem[i]);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout actual=%0d required=<200000", $time);
    $fatal(1);
  end
endmodule

// File: doc/data_mem_responder.md
# data_mem_responder

Multi-cycle responder for the CPU data-memory port. It accepts load/store requests (address, writeData, mode, memRead, memWrite) and performs them against a single-port synchronous word-wide SRAM with registered read data. Sub-word stores are done as read-modify-write. A one-cycle `ack` pulse completes every request. The block replaces the single-cycle data memory when the CPU is built with a stalling data port.

## Interface
- `ADDR_WIDTH`, default 10: SRAM word-address bits; capacity is 2^ADDR_WIDTH words.
- `clk`  in  1  system clock; all logic is on the rising edge.
- `rstN`  in  1  reset, synchronous and active-low.
- `address`  in  32  CPU byte address.
- `writeData`  in  32  store data; sub-word stores use the low bits.
- `mode`  in  2  access size: 00 word, 01 halfword, 10 byte, 11 reserved.
- `memRead`  in  1  load request.
- `memWrite`  in  1  store request.
- `readData`  out  32  load result, zero-extended and right-justified; valid during `ack` and held until the next load completes.
- `ack`  out  1  one-cycle completion pulse.
- `fault`  out  1  valid only with `ack`; 1 means the request was rejected and no SRAM write occurred.
- `sramAddr`  out  ADDR_WIDTH  SRAM word address.
- `sramWData`  out  32  SRAM write data.
- `sramWe`  out  1  SRAM write enable.
- `sramRe`  out  1  SRAM read enable.
- `sramRData`  in  32  SRAM read data; valid the cycle after the cycle in which `sramRe` is high.

## Operation
- Little-endian byte order.
  - Byte lane = `address[1:0]`, bits `[8*k+7:8*k]`.
  - Halfword lane = `address[1]`.
- Request protocol:
  - The CPU holds `memRead`/`memWrite` and the operands stable until `ack`.
  - In the cycle after `ack`, the CPU drops the request or presents a new one.
  - A request is accepted only in IDLE. Its operands are latched at acceptance.
  - Changes to the inputs while busy are ignored.
- Fault conditions, checked at acceptance:
  - `memRead` and `memWrite` both high.
  - `mode` = 11.
  - Halfword with `address[0]` = 1.
  - Word with `address[1:0]` ≠ 0.
  - `address[31:ADDR_WIDTH+2]` ≠ 0.
- A faulting request performs no SRAM access. A faulting load leaves `readData` unchanged.
- FSM states: IDLE, READ, WAIT, WRITE, ACK.
  - IDLE, fault → ACK with `fault` = 1.
  - IDLE, word store → WRITE.
  - IDLE, load or sub-word store → READ.
  - READ → WAIT. `sramRe` = 1 in READ.
  - WAIT, load → ACK. The selected lane of `sramRData` is captured into `readData`, zero-extended.
  - WAIT, sub-word store → WRITE. The merged word is formed: `writeData[7:0]` or `writeData[15:0]` replaces the selected lane; all other bytes come from `sramRData`.
  - WRITE → ACK. `sramWe` = 1 in WRITE, with `sramWData` = full word or merged word.
  - ACK → IDLE. `ack` = 1 in ACK.
- `sramAddr` = `address[ADDR_WIDTH+1:2]` of the latched request. It is held from acceptance until the return to IDLE.
- All outputs are registered. `sramRe` and `sramWe` are never high in the same cycle.

## Timing
- Reset values: state IDLE, and every output 0.
  - `readData`, `ack`, `fault`, `sramAddr`, `sramWData`, `sramWe`, `sramRe` are all 0.
- Latency from the acceptance edge to the `ack` cycle:
  - Fault: 1 cycle.
  - Word store: 2 cycles.
  - Load: 3 cycles.
  - Sub-word store: 4 cycles.
- Back-to-back throughput: a new request can be accepted in the cycle after `ack`. There is no idle bubble beyond the ACK state.
- Reset mid-operation:
  - Next state is IDLE. No `ack` is issued for the aborted request.
  - A store whose `sramWe` was already high in the reset cycle completes at the SRAM.
  - A store not yet in WRITE is dropped. RMW never writes a partially merged word.
- A request present in the reset cycle is not accepted. It is accepted on the first cycle with `rstN` = 1 and state IDLE.

## Test plan
- Word store, then load: store 0xDEADBEEF to 0x10. Required: `ack` 2 cycles after acceptance with `sramWe`=1, `sramAddr`=4. Then a load from 0x10 gives `ack` 3 cycles after acceptance with `readData`=0xDEADBEEF, `fault`=0.
- Byte RMW: with word 4 = 0xDEADBEEF, store byte 0x55 to 0x12. Required: READ/WAIT/WRITE sequence, `sramWData`=0xDE55BEEF, `ack` at cycle 4. A byte load from 0x12 returns 0x00000055.
- Halfword: store 0xA5A5_1234 (half mode) to 0x16, then load a half from 0x16. Required: `readData`=0x00001234, other half of word 5 unchanged.
- Faults, each with `ack`+`fault`=1 one cycle after acceptance and `sramWe`/`sramRe` never high:
  - half access to 0x11;
  - word access to 0x12;
  - `mode`=11;
  - address 0x00001000 with ADDR_WIDTH=10;
  - `memRead` and `memWrite` both high.
- Reset mid-RMW: assert `rstN`=0 during WAIT of a byte store. Required: no `sramWe`, no `ack`, all outputs 0 next cycle; the word is unchanged on reread.
- Back-to-back: a load is presented in the cycle after a store's `ack`. Required: it is accepted in that cycle, and operand changes made while busy have no effect.
